// File: rtl/bcd_to_bin.sv
// rtl/bcd_to_bin.sv - sequential BCD-to-binary converter (reverse double dabble)
// Fixed BIN_W-step latency; blank code 15 allowed only as leading-zero suppression.
module bcd_to_bin #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       bcd_in [0:DIGITS-1],
  output logic             out_valid,
  output logic [BIN_W-1:0] bin_out,
  output logic             err_invalid,
  output logic             err_overflow,
  output logic             busy
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int SR_W  = BCD_W + BIN_W;
  localparam int CNT_W = $clog2(BIN_W + 1);

  typedef enum logic {IDLE, CONV} state_t;

  state_t             state_q, state_d;
  logic [SR_W-1:0]    sr_q;
  logic [SR_W-1:0]    sr_shift;
  logic [CNT_W-1:0]   cnt_q;
  logic               valid_q;
  logic               out_valid_q;
  logic [BIN_W-1:0]   bin_out_q;
  logic               err_invalid_q;
  logic               err_overflow_q;

  logic [BCD_W-1:0]   load_bcd;
  logic               req_ok;
  logic               seen_digit;
  logic               accept;
  logic               last_step;

  // Blanks must form a run from the top digit down; the ones digit is never blank.
  always_comb begin
    req_ok     = 1'b1;
    seen_digit = 1'b0;
    load_bcd   = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if (bcd_in[i] == 4'd15) begin
        if (seen_digit) req_ok = 1'b0;
      end else begin
        seen_digit = 1'b1;
        if (bcd_in[i] > 4'd9) req_ok = 1'b0;
        load_bcd[4*i +: 4] = bcd_in[i];
      end
    end
    if (bcd_in[0] == 4'd15) req_ok = 1'b0;
  end

  // One conversion step: shift right, then correct every BCD nibble that reached 8 or more.
  always_comb begin
    sr_shift = sr_q >> 1;
    for (int i = 0; i < DIGITS; i++) begin
      if (sr_shift[BIN_W + 4*i + 3])
        sr_shift[BIN_W + 4*i +: 4] = sr_shift[BIN_W + 4*i +: 4] - 4'd3;
    end
  end

  assign accept    = in_valid && in_ready;
  assign last_step = (state_q == CONV) && (cnt_q == CNT_W'(BIN_W - 1));

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = CONV;
      CONV:    if (last_step) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state_q == IDLE);
    busy     = (state_q == CONV);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q           <= '0;
      cnt_q          <= '0;
      valid_q        <= 1'b0;
      out_valid_q    <= 1'b0;
      bin_out_q      <= '0;
      err_invalid_q  <= 1'b0;
      err_overflow_q <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      if (accept) begin
        sr_q    <= {load_bcd, {BIN_W{1'b0}}};
        valid_q <= req_ok;
        cnt_q   <= '0;
      end else if (busy) begin
        sr_q  <= sr_shift;
        cnt_q <= cnt_q + CNT_W'(1);
        if (last_step) begin
          out_valid_q    <= 1'b1;
          bin_out_q      <= valid_q ? sr_shift[BIN_W-1:0] : '0;
          err_overflow_q <= valid_q && (sr_shift[SR_W-1:BIN_W] != '0);
          err_invalid_q  <= !valid_q;
        end
      end
    end
  end

  assign out_valid    = out_valid_q;
  assign bin_out      = bin_out_q;
  assign err_invalid  = err_invalid_q;
  assign err_overflow = err_overflow_q;

endmodule
